// File: rtl/imem_fetch_responder_if.sv
`default_nettype none
// ==========================================================================
// imem_fetch_responder_if : fetch-side and backing-memory signal bundle
// Revision 1.0
// ==========================================================================
interface imem_fetch_responder_if #(
   parameter int N = 32
);
   logic [N-1:0] PCF;
   logic         InvalidateI;
   logic [N-1:0] InstrF;
   logic         ImemStallF;
   logic         MemReq;
   logic [N-1:0] MemAddr;
   logic [N-1:0] MemRData;
   logic         MemRValid;
   logic [31:0]  HitCount;
   logic [31:0]  MissCount;

   modport slave (
      input  PCF, InvalidateI, MemRData, MemRValid,
      output InstrF, ImemStallF, MemReq, MemAddr, HitCount, MissCount
   );

   modport master (
      output PCF, InvalidateI, MemRData, MemRValid,
      input  InstrF, ImemStallF, MemReq, MemAddr, HitCount, MissCount
   );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ==========================================================================
// imem_fetch_responder : direct-mapped I-cache with single-request refill FSM
// Revision 1.0
// ==========================================================================
module imem_fetch_responder #(
   parameter int N     = 32,
   parameter int LINES = 16,
   localparam int IDX  = $clog2(LINES)
) (
   input  logic                    clk,
   input  logic                    rst,
   imem_fetch_responder_if.slave   bus
);
   localparam int TW = N - IDX - 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nx;

   logic [LINES-1:0] valid;
   logic [TW-1:0]    tag_mem  [LINES];
   logic [N-1:0]     data_mem [LINES];

   logic [IDX-1:0]  idx;
   logic [TW-1:0]   ptag;
   logic [IDX-1:0]  fill_idx;
   logic [TW-1:0]   fill_tag;
   logic [N-1:0]    mem_addr;
   logic            discard;
   logic            hit;
   logic            miss_start;
   logic            fill_done;
   logic            install;
   logic [N-1:0]    instr;
   logic            stall;
   logic [31:0]     hit_count;
   logic [31:0]     miss_count;
   logic            unused_pcf_lsb;

   assign idx            = bus.PCF[IDX+1:2];
   assign ptag           = bus.PCF[N-1:IDX+2];
   assign fill_idx       = mem_addr[IDX+1:2];
   assign fill_tag       = mem_addr[N-1:IDX+2];
   assign unused_pcf_lsb = ^bus.PCF[1:0];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      hit        = 1'b0;
      instr      = '0;
      stall      = 1'b1;
      miss_start = 1'b0;
      fill_done  = 1'b0;
      case (state)
         IDLE: begin
            if (valid[idx] && (tag_mem[idx] == ptag)) begin
               hit   = 1'b1;
               instr = data_mem[idx];
               stall = 1'b0;
            end else begin
               miss_start = 1'b1;
               state_nx   = FILL;
            end
         end
         FILL: begin
            if (bus.MemRValid) begin
               fill_done = 1'b1;
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // An invalidate arriving with (or before) the response kills the install
   assign install = fill_done && !discard && !bus.InvalidateI;

   always_ff @(posedge clk) begin
      if (rst)                  valid           <= '0;
      else if (bus.InvalidateI) valid           <= '0;
      else if (install)         valid[fill_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (install) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= bus.MemRData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr <= '0;
         discard  <= 1'b0;
      end else begin
         if (miss_start) begin
            mem_addr <= {bus.PCF[N-1:2], 2'b00};
            discard  <= 1'b0;
         end else if (state == FILL && bus.InvalidateI) begin
            discard  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit && hit_count != 32'hFFFF_FFFF)
            hit_count <= hit_count + 32'd1;
         if (miss_start && miss_count != 32'hFFFF_FFFF)
            miss_count <= miss_count + 32'd1;
      end
   end

   assign bus.InstrF     = instr;
   assign bus.ImemStallF = stall;
   assign bus.MemReq     = (state == FILL);
   assign bus.MemAddr    = mem_addr;
   assign bus.HitCount   = hit_count;
   assign bus.MissCount  = miss_count;
endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
`default_nettype none
// ==========================================================================
// tb_imem_fetch_responder : scoreboard bench for imem_fetch_responder
// Revision 1.0
// ==========================================================================
module tb_imem_fetch_responder;
   localparam int LINES = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imem_fetch_responder_if #(.N(32)) bus ();

   imem_fetch_responder #(.N(32), .LINES(LINES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic        stall;
      logic        req;
      logic [31:0] addr;
      logic [31:0] hc;
      logic [31:0] mc;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model: cache contents keyed by line index, holding the word address
   int unsigned line_addr [int];
   int unsigned line_data [int];
   bit          known     = 1'b0;
   bit          busy      = 1'b0;
   bit          discard   = 1'b0;
   logic [31:0] paddr     = '0;
   logic [31:0] last_addr = '0;
   logic [31:0] hc        = '0;
   logic [31:0] mc        = '0;
   int          fill_cnt  = 0;
   int          lat       = 2;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h40) return 32'hE3A0_1005;
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic cyc(input logic [31:0] pcf, input bit inv, input bit r, input bit stray);
      logic        rv;
      logic [31:0] word;
      int          ix;
      bit          hit;
      exp_t        e;
      rv   = stray || (busy && fill_cnt >= lat);
      word = {pcf[31:2], 2'b00};
      ix   = int'((word >> 2) % LINES);
      hit  = !busy && line_addr.exists(ix) && (line_addr[ix] == word);

      rst             = r;
      bus.PCF         = pcf;
      bus.InvalidateI = inv;
      bus.MemRValid   = rv;
      bus.MemRData    = busy ? mem_word(paddr) : $urandom;

      if (known) begin
         e.instr = hit ? line_data[ix] : 32'h0;
         e.stall = !hit;
         e.req   = busy;
         e.addr  = last_addr;
         e.hc    = hc;
         e.mc    = mc;
         q.push_back(e);
      end

      @(posedge clk);
      #1;
      if (r) begin
         known = 1'b1;
         busy = 1'b0; discard = 1'b0; last_addr = '0; hc = '0; mc = '0;
         line_addr.delete();
         line_data.delete();
      end else if (!busy) begin
         if (hit && hc != 32'hFFFF_FFFF) hc = hc + 1;
         if (inv) begin
            line_addr.delete();
            line_data.delete();
         end
         if (!hit) begin
            busy = 1'b1; discard = 1'b0; fill_cnt = 0;
            paddr = word; last_addr = word;
            if (mc != 32'hFFFF_FFFF) mc = mc + 1;
         end
      end else begin
         if (inv) begin
            line_addr.delete();
            line_data.delete();
            discard = 1'b1;
         end
         if (rv) begin
            if (!discard) begin
               line_addr[int'((paddr >> 2) % LINES)] = paddr;
               line_data[int'((paddr >> 2) % LINES)] = mem_word(paddr);
            end
            busy = 1'b0;
         end else begin
            fill_cnt++;
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      exp_t g;
      if (q.size() > 0) begin
         e = q.pop_front();
         g.instr = bus.InstrF;
         g.stall = bus.ImemStallF;
         g.req   = bus.MemReq;
         g.addr  = bus.MemAddr;
         g.hc    = bus.HitCount;
         g.mc    = bus.MissCount;
         n_vec++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL cycle_outputs t=%0t got instr=%h stall=%b req=%b addr=%h hit=%0d miss=%0d | want instr=%h stall=%b req=%b addr=%h hit=%0d miss=%0d",
                     $time, g.instr, g.stall, g.req, g.addr, g.hc, g.mc,
                     e.instr, e.stall, e.req, e.addr, e.hc, e.mc);
         end
      end
   end

   initial begin
      logic [31:0] pool [8];
      logic [31:0] cur;
      int          run;
      rst = 1'b1; bus.PCF = '0; bus.InvalidateI = 1'b0;
      bus.MemRValid = 1'b0; bus.MemRData = '0;
      @(posedge clk); #1;

      lat = 2;
      repeat (2) cyc(32'h40, 0, 1, 0);
      // Cold miss then hits
      repeat (4) cyc(32'h40, 0, 0, 0);
      repeat (5) cyc(32'h40, 0, 0, 0);
      // Conflict on line 0
      repeat (5) cyc(32'h80, 0, 0, 0);
      repeat (5) cyc(32'h40, 0, 0, 0);
      // Redirect while a fill is outstanding
      cyc(32'h104, 0, 0, 0);
      repeat (8) cyc(32'h208, 0, 0, 0);
      repeat (2) cyc(32'h104, 0, 0, 0);
      // Invalidate in IDLE, then invalidate during a fill
      cyc(32'h40, 1, 0, 0);
      cyc(32'h40, 0, 0, 0);
      cyc(32'h40, 0, 0, 0);
      cyc(32'h40, 1, 0, 0);
      cyc(32'h40, 0, 0, 0);
      repeat (5) cyc(32'h40, 0, 0, 0);
      // Reset in the middle of a fill with a stray response
      cyc(32'h80, 0, 0, 0);
      cyc(32'h80, 0, 0, 0);
      cyc(32'h80, 0, 1, 0);
      cyc(32'h80, 0, 1, 0);
      cyc(32'h80, 0, 1, 1);
      repeat (5) cyc(32'h80, 0, 0, 0);

      for (int i = 0; i < 8; i++) pool[i] = 32'($urandom_range(0, 127)) << 2;
      run = 0;
      cur = pool[0];
      for (int i = 0; i < 600; i++) begin
         if (!busy) lat = $urandom_range(0, 4);
         if (run == 0) begin
            cur = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            run = $urandom_range(1, 6);
         end
         run--;
         cyc(cur, ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0),
             (!busy && $urandom_range(0, 9) == 0));
      end

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL scoreboard_drain left=%0d want=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
